// File: rtl/moving_sum.sv
// Moving-window signed accumulator over the last 2**DEPTH_LOG2 accepted samples.
// Emits the registered window sum and its floor-mean each accepted sample.
module moving_sum #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        ivalid,
  input  logic [WIDTH-1:0]            idata,
  output logic                        ovalid,
  output logic [WIDTH+DEPTH_LOG2-1:0] osum,
  output logic [WIDTH-1:0]            odata,
  output logic                        full
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned SumW  = WIDTH + DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [SumW-1:0]       acc_q, acc_d;
  logic                  full_q, full_d;
  logic                  ovalid_q, ovalid_d;
  logic                  accept;
  logic [WIDTH-1:0]      oldest;

  assign accept = ivalid & ~clear;

  always_comb begin
    oldest   = full_q ? mem_q[wptr_q] : '0;
    wptr_d   = wptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    full_d   = full_q;
    ovalid_d = 1'b0;
    if (clear) begin
      wptr_d  = '0;
      count_d = '0;
      acc_d   = '0;
      full_d  = 1'b0;
    end else if (ivalid) begin
      acc_d    = acc_q + {{DEPTH_LOG2{idata[WIDTH-1]}}, idata}
                       - {{DEPTH_LOG2{oldest[WIDTH-1]}}, oldest};
      wptr_d   = wptr_q + 1'b1;
      count_d  = (count_q == DepthCnt) ? count_q : count_q + 1'b1;
      full_d   = (count_d == DepthCnt);
      ovalid_d = full_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      full_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      full_q   <= full_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Stale entries are never read before being rewritten, so no reset is needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[wptr_q] <= idata;
    end
  end

  // The accumulator is only loaded on accepted samples, so it doubles as osum.
  assign osum   = acc_q;
  assign odata  = acc_q[SumW-1:DEPTH_LOG2];
  assign ovalid = ovalid_q;
  assign full   = full_q;

endmodule

// File: tb/tb_moving_sum.sv
// Directed bench for moving_sum: table-driven signed vectors plus hand sequences
// for ramp, gapped input, wrap-around, clear collision and asynchronous reset.
module tb_moving_sum;
  localparam int W = 16;
  localparam int L = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                clear = 1'b0;
  logic                ivalid = 1'b0;
  logic [W-1:0]        idata = '0;
  logic                ovalid, full;
  logic signed [W+L-1:0] osum;
  logic signed [W-1:0]   odata;

  int n_cmp = 0;
  int n_bad = 0;
  int win[$];

  typedef struct {
    bit clr; bit iv; int d;
    bit ov;  int sum; int od; bit fl;
  } vec_t;
  vec_t tbl[20];

  moving_sum #(.WIDTH(W), .DEPTH_LOG2(L)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .ivalid(ivalid),
    .idata (idata),
    .ovalid(ovalid),
    .osum  (osum),
    .odata (odata),
    .full  (full)
  );

  always #5 clock = ~clock;

  task automatic check(string name, bit eov, int esum, int eod, bit efl);
    logic signed [W+L-1:0] xs;
    logic signed [W-1:0]   xd;
    xs = (W+L)'(esum);
    xd = W'(eod);
    n_cmp++;
    if (ovalid !== eov || osum !== xs || odata !== xd || full !== efl) begin
      n_bad++;
      $display("FAIL %s: got ov=%0b sum=%0d odata=%0d full=%0b, want ov=%0b sum=%0d odata=%0d full=%0b",
               name, ovalid, osum, odata, full, eov, esum, eod, efl);
    end
  endtask

  task automatic cyc(bit c, bit v, int d);
    clear  = c;
    ivalid = v;
    idata  = W'(d);
    @(posedge clock);
    #1;
    clear  = 1'b0;
    ivalid = 1'b0;
  endtask

  task automatic macc(int d);
    win.push_back(d);
    if (win.size() > 8) void'(win.pop_front());
  endtask

  task automatic mcheck(string name, bit acc);
    int s;
    s = 0;
    foreach (win[i]) s += win[i];
    check(name, acc && win.size() == 8, s, s >>> 3, win.size() == 8);
  endtask

  task automatic do_clear();
    cyc(1'b1, 1'b0, 0);
    win.delete();
    check("clear", 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    // Signed vectors applied from an empty window.
    for (int k = 1; k <= 8; k++) tbl[k-1] = '{0, 1, -8, k == 8, -8 * k, -k, k == 8};
    tbl[8]  = '{0, 1, 7, 1, -49, -7, 1};
    tbl[9]  = '{0, 0, 3, 0, -49, -7, 1};
    tbl[10] = '{1, 1, 5, 0, 0, 0, 0};
    for (int k = 0; k < 7; k++) tbl[11+k] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 1, -1, 1, -1, -1, 1};
    tbl[19] = '{0, 1, -1, 1, -2, -1, 1};

    #12;
    check("reset_state", 1'b0, 0, 0, 1'b0);
    #1 reset = 1'b0;

    // Counting ramp from the first post-reset edge.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, i);
      macc(i);
      mcheck("ramp", 1'b1);
      if (i == 7) check("ramp_first", 1'b1, 28, 3, 1'b1);
      if (i == 8) check("ramp_second", 1'b1, 36, 4, 1'b1);
    end

    do_clear();
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].clr, tbl[i].iv, tbl[i].d);
      check($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].sum, tbl[i].od, tbl[i].fl);
    end

    // One valid every three cycles.
    do_clear();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, i);
      macc(i);
      mcheck("gap_acc", 1'b1);
      repeat (2) begin
        cyc(1'b0, 1'b0, 99);
        mcheck("gap_hold", 1'b0);
      end
    end

    do_clear();
    for (int i = 100; i < 120; i++) cyc(1'b0, 1'b1, i);
    check("wrap", 1'b1, 924, 115, 1'b1);

    // Clear collides with the 10th sample.
    do_clear();
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, i);
    cyc(1'b1, 1'b1, 9);
    check("clr_drop", 1'b0, 0, 0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 1);
      check("clr_refill", k == 8, k, (k == 8) ? 1 : 0, k == 8);
    end

    // Asynchronous reset pulse mid-cycle while running.
    do_clear();
    for (int i = 1; i <= 12; i++) cyc(1'b0, 1'b1, i);
    check("pre_rst", 1'b1, 5+6+7+8+9+10+11+12, 68 >>> 3, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("async_rst", 1'b0, 0, 0, 1'b0);
    #2 reset = 1'b0;
    win.delete();
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 5);
      macc(5);
      mcheck("rst_refill", 1'b1);
    end
    check("rst_refill_end", 1'b1, 40, 5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/moving_sum.md
# moving_sum

Streaming moving-window accumulator that sits directly downstream of the `shiftTaps` tap stage. It consumes the valid-tagged sample stream (`ovalid`/`shiftout` of the tap stage) and keeps the signed sum of the most recent `2**DEPTH_LOG2` accepted samples in an internal circular buffer. Each accepted sample produces a registered window sum and its arithmetic-mean approximation.

## Interface
- `WIDTH`, default 32: sample width; samples are signed two's complement.
- `DEPTH_LOG2`, default 3: log2 of the window length. `DEPTH = 2**DEPTH_LOG2`, legal range 1..8.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset of all state.
- `clear` input 1: synchronous flush of the window; takes priority over `ivalid`.
- `ivalid` input 1: `idata` is a valid sample this cycle.
- `idata` input `WIDTH`: signed input sample.
- `ovalid` output 1: one-cycle pulse; `osum`/`odata` were updated with a full window.
- `osum` output `WIDTH+DEPTH_LOG2`: signed sum of the last `DEPTH` accepted samples.
- `odata` output `WIDTH`: `osum >>> DEPTH_LOG2` (arithmetic shift, rounds toward −inf).
- `full` output 1: window holds `DEPTH` samples.

## Operation
- State:
  - circular buffer `buf[0..DEPTH-1]` of `WIDTH` bits
  - write pointer `wptr` (`DEPTH_LOG2` bits, wraps modulo `DEPTH`)
  - fill counter `count` (0..`DEPTH`, saturating)
  - accumulator `acc` (`WIDTH+DEPTH_LOG2` bits, signed)
- Accepted sample (`ivalid=1`, `clear=0`):
  - `oldest = full ? buf[wptr] : 0`
  - `acc <= acc + sext(idata) - sext(oldest)`
  - `buf[wptr] <= idata`
  - `wptr <= wptr+1`
  - `count <= min(count+1, DEPTH)`
- Accumulator width is exact; it never overflows for any `WIDTH`-bit signed input stream.
- Outputs on an accepted sample:
  - `osum` and `odata` register the new `acc` value on every accepted sample, including during warm-up.
  - `ovalid` is high only if the post-update `count == DEPTH`.
- Cycles with `ivalid=0`: all state and `osum`/`odata` hold; `ovalid=0`.
- `clear=1`:
  - Next edge: `count`, `wptr`, `acc`, `osum`, `odata`, `ovalid` go to 0. `buf` contents are left undefined-but-ignored.
  - A sample presented in the same cycle is dropped.
- Buffer contents are never read while `count < DEPTH`, so `buf` needs no reset.
- Two states, implied by `count`:
  - FILL (`count < DEPTH`): FILL → RUN when the `DEPTH`-th sample is accepted.
  - RUN (`count == DEPTH`): RUN → FILL only on `clear` or `reset`.
- `full = (count == DEPTH)`, registered.

## Timing
- Latency: a sample accepted at edge k appears in `osum`/`odata`, with `ovalid` high, in the cycle after edge k (1 clock).
- Throughput: one sample per clock, with no backpressure. `ivalid` may be held high indefinitely.
- First `ovalid` after reset or clear: in the cycle after the `DEPTH`-th accepted sample. Gaps in `ivalid` delay it accordingly.
- `reset` assertion (asynchronous): immediately forces `ovalid`, `osum`, `odata`, `full`, `count`, `wptr`, `acc` to 0. This includes mid-window; the partial window is discarded.
- Reset deassertion: the first edge with `reset=0` may accept a sample.
- Wrap-around: when `wptr` wraps from `DEPTH-1` to 0, there is no bubble. The sample at `buf[0]` is the one subtracted next.
- Simultaneous `clear` and `ivalid`: `clear` wins and the sample is lost. `ovalid` is 0 in the following cycle.

## Test plan
- Counting ramp 0,1,2,… with `ivalid=1` from the first post-reset edge, `DEPTH_LOG2=3`:
  - `ovalid` low for the first 7 outputs.
  - First `ovalid`: `osum=28`, `odata=3`.
  - Next: `osum=36`, `odata=4`.
  - Thereafter `osum` grows by 8 per cycle.
- Signed values:
  - Eight samples of −8: `osum=-64`, `odata=-8`.
  - Then one sample of 7 replacing a −8: `osum=-49`, `odata=-7`. Floor check: −49>>>3 = −7.
  - Seven 0s and one −1: `odata=-1`.
- Gapped `ivalid` (1 valid every 3 cycles, ramp 0..15): `ovalid` pulses exactly once per accepted sample from the 8th on. `osum`/`odata` hold in gap cycles. Sums match the ungapped case (28, 36, …).
- Wrap-around: stream of 20 samples 100..119. After sample 119, `osum` = 112+…+119 = 924 and `odata=115`.
- `clear` asserted together with the 10th sample of a ramp:
  - That sample is dropped.
  - `osum=0`, `full=0` next cycle.
  - Refill with 1,1,…: first `ovalid` after 8 samples with `osum=8`, `odata=1`.
- Asynchronous `reset` pulse mid-cycle, in RUN after 12 samples: all outputs 0 before the next edge. Refill behaves as after power-on (first `ovalid` after 8 samples).
